// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream multiplexer family.
package stream_mux_pkg;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_SEL = 1'b1;

   // Next channel index with wrap-around at n.
   function automatic int next_ch(input int ch, input int n);
      return (ch + 1 >= n) ? 0 : ch + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of i_req at or after
// i_start, searching upward with wrap.
module rr_pick #(
   parameter int N_CH = 8,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [CH_W-1:0] i_start,
   output logic            o_found,
   output logic [CH_W-1:0] o_idx
);

   always_comb begin
      logic [CH_W-1:0] w_c;
      w_c     = {CH_W{1'b0}};
      o_found = 1'b0;
      o_idx   = {CH_W{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         w_c     = CH_W'((32'(i_start) + 32'(k)) % 32'(N_CH));
         o_idx   = (i_req[w_c] && !o_found) ? w_c : o_idx;
         o_found = o_found | i_req[w_c];
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 packet stream multiplexer with round-robin or forced select, packet
// locking and a registered output stage.
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter int N_CH   = 8,
   parameter int DATA_W = 8,
   parameter int CH_W   = $clog2(N_CH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_mode,
   input  logic [CH_W-1:0]        i_sel,
   input  logic [N_CH-1:0]        i_in_valid,
   input  logic [N_CH*DATA_W-1:0] i_in_data,
   input  logic [N_CH-1:0]        i_in_last,
   output logic [N_CH-1:0]        o_in_ready,
   output logic                   o_out_valid,
   output logic [DATA_W-1:0]      o_out_data,
   output logic                   o_out_last,
   output logic [CH_W-1:0]        o_out_ch,
   input  logic                   i_out_ready
);

   localparam logic [CH_W:0]   LP_N    = (CH_W+1)'(N_CH);
   localparam logic [CH_W-1:0] LP_LAST = CH_W'(N_CH - 1);

   state_t              r_state;
   logic [CH_W-1:0]     r_owner;
   logic [CH_W-1:0]     r_last_grant;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_last;
   logic [CH_W-1:0]     r_out_ch;

   logic [CH_W-1:0]     w_start;
   logic                w_rr_found;
   logic [CH_W-1:0]     w_rr_idx;
   logic                w_sel_ok;
   logic                w_have;
   logic [CH_W-1:0]     w_grant;
   logic                w_space;
   logic                w_open;
   logic                w_xfer;
   logic [DATA_W-1:0]   w_beat_data;
   logic                w_beat_last;

   assign w_start = CH_W'(next_ch(int'(r_last_grant), N_CH));

   rr_pick #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr_pick (
      .i_req   (i_in_valid),
      .i_start (w_start),
      .o_found (w_rr_found),
      .o_idx   (w_rr_idx)
   );

   assign w_sel_ok = ({1'b0, i_sel} < LP_N);

   // An owned channel keeps the grant regardless of mode/sel until its last beat.
   always_comb begin
      w_have  = 1'b0;
      w_grant = r_owner;
      if (r_state == S_LOCKED) begin
         w_have  = 1'b1;
         w_grant = r_owner;
      end else if (i_mode == MODE_RR) begin
         w_have  = w_rr_found;
         w_grant = w_rr_idx;
      end else begin
         w_have  = w_sel_ok && i_in_valid[i_sel];
         w_grant = i_sel;
      end
   end

   assign w_space = !r_out_valid || i_out_ready;
   assign w_open  = w_have && w_space && !i_rst;
   assign w_xfer  = w_open && i_in_valid[w_grant];

   always_comb begin
      o_in_ready          = {N_CH{1'b0}};
      o_in_ready[w_grant] = w_open;
   end

   // Constant-index mux keeps the data path free of variable part-selects.
   always_comb begin
      w_beat_data = {DATA_W{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         w_beat_data = (w_grant == CH_W'(i)) ? i_in_data[i*DATA_W +: DATA_W] : w_beat_data;
      end
   end

   assign w_beat_last = i_in_last[w_grant];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_owner      <= {CH_W{1'b0}};
         r_last_grant <= LP_LAST;
         r_out_valid  <= 1'b0;
         r_out_data   <= {DATA_W{1'b0}};
         r_out_last   <= 1'b0;
         r_out_ch     <= {CH_W{1'b0}};
      end else if (w_xfer) begin
         r_state      <= w_beat_last ? S_IDLE : S_LOCKED;
         r_owner      <= w_grant;
         r_last_grant <= w_grant;
         r_out_valid  <= 1'b1;
         r_out_data   <= w_beat_data;
         r_out_last   <= w_beat_last;
         r_out_ch     <= w_grant;
      end else if (i_out_ready) begin
         r_out_valid  <= 1'b0;
      end else begin
         r_out_valid  <= r_out_valid;
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: queue-fed producers, a per-cycle
// reference model and literal checks of the observed output beat order.
module tb_stream_mux_arb;
   import stream_mux_pkg::*;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            mode;
   logic [CW-1:0]   sel;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [CW-1:0]   out_ch;
   logic            out_ready;

   typedef struct {logic [7:0] d; logic l;} beat_t;
   typedef struct {int ch; int d; int l; int cyc;} obs_t;

   beat_t q [N][$];
   obs_t  log_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc   = 0;

   always #5 clk = ~clk;

   stream_mux_arb #(.N_CH(N), .DATA_W(DW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mode      (mode),
      .i_sel       (sel),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .i_in_last   (in_last),
      .o_in_ready  (in_ready),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .o_out_ch    (out_ch),
      .i_out_ready (out_ready)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit bit_at(input logic [N-1:0] v, input int i);
      logic [CW-1:0] ix;
      ix = CW'(i);
      return v[ix];
   endfunction

   task automatic push(input int ch, input int d, input bit l);
      beat_t b;
      b.d = 8'(d);
      b.l = l;
      q[ch].push_back(b);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_mid();
      @(negedge clk);
      #3;
   endtask

   task automatic chk_log(input int i, input int ch, input int d);
      if (i >= log_q.size()) begin
         n_vec++;
         n_err++;
         $display("FAIL log[%0d]: got no beat expected ch%0d data %0h", i, ch, d);
      end else begin
         chk($sformatf("log[%0d].ch", i), 64'(log_q[i].ch), 64'(ch));
         chk($sformatf("log[%0d].data", i), 64'(log_q[i].d), 64'(d));
      end
   endtask

   task automatic chk_contig(input int from, input int to);
      for (int i = from + 1; i <= to; i++) begin
         if (i < log_q.size()) begin
            chk($sformatf("no_bubble[%0d]", i), 64'(log_q[i].cyc - log_q[i-1].cyc), 64'd1);
         end else begin
            n_vec++;
            n_err++;
            $display("FAIL no_bubble[%0d]: got missing beat expected consecutive cycle", i);
         end
      end
   endtask

   // Producers: present queue heads at negedge, pop whatever was accepted.
   initial begin
      logic [N-1:0] acc;
      in_valid = '0;
      in_data  = '0;
      in_last  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
               in_valid[i]         = 1'b1;
               in_data[i*DW +: DW] = q[i][0].d;
               in_last[i]          = q[i][0].l;
            end else begin
               in_valid[i]         = 1'b0;
               in_data[i*DW +: DW] = 8'h00;
               in_last[i]          = 1'b0;
            end
         end
         #4;
         acc = in_valid & in_ready;
         @(posedge clk);
         for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(q[i].pop_front());
         end
      end
   end

   // Reference model: owner (-1 = none), last grant and the output beat.
   initial begin
      int   m_owner, m_lg, m_och, m_od, n_owner, n_lg, n_och, n_od, g;
      logic m_ov, m_ol, n_ov, n_ol, space, xfer;
      logic [N-1:0] exp_rdy;
      m_owner = -1; m_lg = N - 1; m_ov = 1'b0; m_od = 0; m_ol = 1'b0; m_och = 0;
      forever begin
         @(negedge clk);
         #2;
         space = !m_ov || out_ready;
         g = -1;
         if (m_owner >= 0) g = m_owner;
         else if (mode == MODE_RR) begin
            for (int k = 1; k <= N; k++) begin
               if (g < 0 && bit_at(in_valid, (m_lg + k) % N)) g = (m_lg + k) % N;
            end
         end else if (in_valid[sel]) g = int'(sel);
         exp_rdy = (!rst && space && g >= 0) ? (N'(1) << g) : '0;
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("out_valid", 64'(out_valid), 64'(m_ov));
         chk("out_data", 64'(out_data), 64'(m_od));
         chk("out_last", 64'(out_last), 64'(m_ol));
         chk("out_ch", 64'(out_ch), 64'(m_och));
         if (out_valid && out_ready && !rst)
            log_q.push_back('{int'(out_ch), int'(out_data), int'(out_last), cyc});
         xfer = (exp_rdy != '0) && bit_at(in_valid, g);
         n_owner = m_owner; n_lg = m_lg; n_ov = m_ov; n_od = m_od; n_ol = m_ol; n_och = m_och;
         if (rst) begin
            n_owner = -1; n_lg = N - 1; n_ov = 1'b0; n_od = 0; n_ol = 1'b0; n_och = 0;
         end else if (xfer) begin
            n_ov    = 1'b1;
            n_od    = int'(8'(in_data >> (g * DW)));
            n_ol    = bit_at(in_last, g);
            n_och   = g;
            n_lg    = g;
            n_owner = n_ol ? -1 : g;
         end else if (out_ready) begin
            n_ov = 1'b0;
         end
         @(posedge clk);
         cyc++;
         m_owner = n_owner; m_lg = n_lg; m_ov = n_ov; m_od = n_od; m_ol = n_ol; m_och = n_och;
      end
   end

   initial begin
      rst = 1'b1; mode = MODE_RR; sel = '0; out_ready = 1'b1;
      tick(3);
      at_mid();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      tick(1);
      rst = 1'b0;

      // Idle after reset
      repeat (5) begin
         at_mid();
         chk("idle_out_valid", 64'(out_valid), 64'd0);
         chk("idle_out_ch", 64'(out_ch), 64'd0);
         chk("idle_in_ready", 64'(in_ready), 64'd0);
      end

      // Round-robin fairness over ch2/ch5/ch7
      tick(1);
      log_q.delete();
      for (int k = 0; k < 3; k++) begin
         push(2, 8'h20 + k, 1'b1);
         push(5, 8'h50 + k, 1'b1);
         push(7, 8'h70 + k, 1'b1);
      end
      tick(14);
      chk("rr_count", 64'(log_q.size()), 64'd9);
      for (int k = 0; k < 3; k++) begin
         chk_log(3*k,     2, 8'h20 + k);
         chk_log(3*k + 1, 5, 8'h50 + k);
         chk_log(3*k + 2, 7, 8'h70 + k);
      end
      chk_contig(0, 8);

      // Packet lock: ch1 four beats while ch0 stays valid
      log_q.delete();
      push(0, 8'h01, 1'b1);
      tick(4);
      push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b0); push(1, 8'hA4, 1'b1);
      push(0, 8'h0F, 1'b1);
      tick(10);
      chk("lock_count", 64'(log_q.size()), 64'd6);
      chk_log(0, 0, 8'h01);
      chk_log(1, 1, 8'hA1); chk_log(2, 1, 8'hA2); chk_log(3, 1, 8'hA3); chk_log(4, 1, 8'hA4);
      chk_log(5, 0, 8'h0F);
      chk_contig(1, 5);

      // Forced select, sel changed mid-packet
      log_q.delete();
      mode = MODE_SEL; sel = 3'd3;
      for (int i = 0; i < N; i++) begin
         if (i == 3) begin
            push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
         end else if (i == 6) begin
            push(6, 8'h61, 1'b0); push(6, 8'h62, 1'b1);
         end else begin
            push(i, 8'hC0 + i, 1'b1);
         end
      end
      at_mid();
      chk("sel3_in_ready", 64'(in_ready), 64'h08);
      tick(1);
      sel = 3'd6;
      at_mid();
      chk("sel_locked_in_ready", 64'(in_ready), 64'h08);
      tick(8);
      at_mid();
      chk("sel6_empty_in_ready", 64'(in_ready), 64'h00);
      chk("sel_count", 64'(log_q.size()), 64'd5);
      chk_log(0, 3, 8'h31); chk_log(1, 3, 8'h32); chk_log(2, 3, 8'h33);
      chk_log(3, 6, 8'h61); chk_log(4, 6, 8'h62);
      chk_contig(0, 4);
      tick(1);
      mode = MODE_RR;
      tick(10);
      chk_log(5, 7, 8'hC7); chk_log(6, 0, 8'hC0); chk_log(7, 1, 8'hC1);
      chk_log(8, 2, 8'hC2); chk_log(9, 4, 8'hC4); chk_log(10, 5, 8'hC5);
      chk_contig(5, 10);

      // Backpressure with 0x5C held for 3 cycles
      log_q.delete();
      out_ready = 1'b0;
      push(4, 8'h5C, 1'b1); push(4, 8'h5D, 1'b1);
      at_mid();
      chk("bp_first_in_ready", 64'(in_ready), 64'h10);
      repeat (3) begin
         at_mid();
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_out_data", 64'(out_data), 64'h5C);
         chk("bp_in_ready", 64'(in_ready), 64'h00);
      end
      tick(1);
      out_ready = 1'b1;
      tick(4);
      chk("bp_count", 64'(log_q.size()), 64'd2);
      chk_log(0, 4, 8'h5C); chk_log(1, 4, 8'h5D);
      chk_contig(0, 1);

      // Reset mid-packet drops ch5's lock and restores ch0 priority
      push(5, 8'hB1, 1'b0); push(5, 8'hB2, 1'b0); push(5, 8'hB3, 1'b1);
      tick(2);
      rst = 1'b1;
      for (int i = 0; i < N; i++) q[i].delete();
      tick(2);
      at_mid();
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      tick(1);
      rst = 1'b0;
      log_q.delete();
      push(0, 8'hD0, 1'b1); push(5, 8'hD5, 1'b1); push(7, 8'hD7, 1'b1);
      tick(6);
      chk("post_rst_count", 64'(log_q.size()), 64'd3);
      chk_log(0, 0, 8'hD0); chk_log(1, 5, 8'hD5); chk_log(2, 7, 8'hD7);

      // Wrap-around: last grant 7, ch0 and ch6 valid
      log_q.delete();
      push(6, 8'hE6, 1'b1); push(0, 8'hE0, 1'b1);
      tick(5);
      chk("wrap_count", 64'(log_q.size()), 64'd2);
      chk_log(0, 0, 8'hE0); chk_log(1, 6, 8'hE6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
